// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, then shifts out
// eight data bits, odd parity and stop on device clocks and samples the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_RTS      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PARITY   = 3'd4,
    ST_STOP     = 3'd5,
    ST_ACK_WAIT = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t        state_r, state_next;
  logic [IW-1:0] icnt_r, icnt_next;
  logic [TW-1:0] tcnt_r, tcnt_next, tcnt_inc_s;
  logic [3:0]    idx_r, idx_next;
  logic [7:0]    shift_r, shift_next;
  logic          clk_low_r, clk_low_next;
  logic          data_low_r, data_low_next;
  logic          ack_r, ack_next;
  logic          done_r, done_next;
  logic          error_r, error_next;
  logic          tx_ready_r, busy_r;
  logic          clk_meta_r, clk_sync_r, clk_hist_r;
  logic          data_meta_r, data_sync_r;
  logic          clk_fall_s, timed_s;

  assign clk_fall_s = clk_hist_r & ~clk_sync_r;
  assign timed_s    = (state_r == ST_RTS) || (state_r == ST_DATA) || (state_r == ST_PARITY) ||
                      (state_r == ST_STOP) || (state_r == ST_ACK_WAIT);
  assign tcnt_inc_s = tcnt_r + TW'(1);

  // Pin synchronisers; the bus idles high so they reset to 1
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_hist_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_in;
      clk_sync_r  <= clk_meta_r;
      clk_hist_r  <= clk_sync_r;
      data_meta_r <= ps2_data_in;
      data_sync_r <= data_meta_r;
    end
  end

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    state_next    = state_r;
    icnt_next     = icnt_r;
    tcnt_next     = tcnt_r;
    idx_next      = idx_r;
    shift_next    = shift_r;
    clk_low_next  = clk_low_r;
    data_low_next = data_low_r;
    ack_next      = ack_r;
    done_next     = 1'b0;
    error_next    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (tx_valid) begin
          state_next    = ST_INHIBIT;
          icnt_next     = '0;
          shift_next    = tx_data;
          ack_next      = 1'b0;
          clk_low_next  = 1'b1;
          data_low_next = 1'b0;
        end else begin
          clk_low_next  = 1'b0;
          data_low_next = 1'b0;
        end
      end
      ST_INHIBIT: begin
        if (icnt_r == IW'(INHIBIT_CYCLES - 1)) begin
          state_next    = ST_RTS;
          tcnt_next     = '0;
          clk_low_next  = 1'b0;
          data_low_next = 1'b1;
        end else begin
          icnt_next = icnt_r + IW'(1);
        end
      end
      ST_RTS: begin
        state_next = ST_DATA;
        idx_next   = 4'd0;
      end
      ST_DATA: begin
        if (clk_fall_s) begin
          if (idx_r == 4'd8) begin
            data_low_next = ~odd_parity(shift_r);
            state_next    = ST_PARITY;
          end else begin
            data_low_next = ~shift_r[idx_r[2:0]];
            idx_next      = idx_r + 4'd1;
          end
        end else begin
          idx_next = idx_r;
        end
      end
      ST_PARITY: begin
        if (clk_fall_s) begin
          data_low_next = 1'b0;
          state_next    = ST_STOP;
        end else begin
          state_next = ST_PARITY;
        end
      end
      ST_STOP: begin
        // Device already holds data low for ACK when it drops the 11th clock
        if (clk_fall_s) begin
          ack_next   = ~data_sync_r;
          state_next = ST_ACK_WAIT;
        end else begin
          state_next = ST_STOP;
        end
      end
      ST_ACK_WAIT: begin
        if (clk_sync_r && data_sync_r) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          state_next = ST_ACK_WAIT;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next    = ST_IDLE;
        clk_low_next  = 1'b0;
        data_low_next = 1'b0;
      end
    endcase

    // Timeout overrides any bus progress in the same cycle
    if (timed_s) begin
      if (tcnt_inc_s == TW'(TIMEOUT_CYCLES)) begin
        state_next    = ST_IDLE;
        clk_low_next  = 1'b0;
        data_low_next = 1'b0;
        done_next     = 1'b0;
        error_next    = 1'b1;
        tcnt_next     = tcnt_inc_s;
      end else begin
        tcnt_next = tcnt_inc_s;
      end
    end else begin
      error_next = 1'b0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      icnt_r     <= '0;
      tcnt_r     <= '0;
      idx_r      <= 4'd0;
      shift_r    <= 8'd0;
      clk_low_r  <= 1'b0;
      data_low_r <= 1'b0;
      ack_r      <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next;
      icnt_r     <= icnt_next;
      tcnt_r     <= tcnt_next;
      idx_r      <= idx_next;
      shift_r    <= shift_next;
      clk_low_r  <= clk_low_next;
      data_low_r <= data_low_next;
      ack_r      <= ack_next;
      done_r     <= done_next;
      error_r    <= error_next;
      tx_ready_r <= (state_next == ST_IDLE);
      busy_r     <= (state_next != ST_IDLE);
    end
  end

  assign tx_ready           = tx_ready_r;
  assign busy               = busy_r;
  assign ps2_clk_drive_low  = clk_low_r;
  assign ps2_data_drive_low = data_low_r;
  assign done               = done_r;
  assign ack_ok             = ack_r;
  assign error              = error_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host, and each captured frame is compared with one built from the byte value.
module tb_ps2_host_tx;

  localparam int INH = 8;
  localparam int TMO = 2000;

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, busy, done, ack_ok, error;
  logic       clk_dl, data_dl;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic last_ack = 1'b0;

  // Open-drain bus: a line is low if either side pulls it
  assign ps2_clk_in  = ~(clk_dl | dev_clk_low);
  assign ps2_data_in = ~(data_dl | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(clk_dl), .ps2_data_drive_low(data_dl),
    .done(done), .ack_ok(ack_ok), .error(error)
  );

  always #5 clock = ~clock;

  // Pulse monitor
  always @(negedge clock) begin
    if (done) begin
      done_cnt++;
      last_ack = ack_ok;
    end
    if (error) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame as the device sees it: 8 data bits LSB first, odd parity, stop
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  task automatic wait_rts(output int inh_len, output bit seen, output bit busy_ok);
    inh_len = 0; seen = 1'b0; busy_ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (data_dl && !clk_dl) begin
        seen = 1'b1;
        break;
      end
      if (clk_dl) begin
        inh_len++;
        if (!busy || tx_ready) busy_ok = 1'b0;
      end
    end
  endtask

  task automatic device_xfer(input bit do_ack, output logic [9:0] cap);
    cap = '0;
    repeat (5) @(negedge clock);
    for (int e = 1; e <= 11; e++) begin
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clock);
      dev_clk_low = 1'b0;
      if (e <= 10) cap[e-1] = ps2_data_in;
      if (e == 11) dev_data_low = 1'b0;
      if (e == 10 && do_ack) begin
        repeat (5) @(negedge clock);
        dev_data_low = 1'b1;
        repeat (5) @(negedge clock);
      end else begin
        repeat (10) @(negedge clock);
      end
    end
  endtask

  task automatic do_xfer(input string tag, input logic [7:0] b, input bit ack);
    int n; bit seen, bok; logic [9:0] cap; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clock);
    tx_valid = 1'b1; tx_data = b;
    wait_rts(n, seen, bok);
    tx_valid = 1'b0; tx_data = 8'($urandom);
    check({tag, "_rts"}, 32'(seen), 32'd1);
    check({tag, "_inhibit_len"}, 32'(n), 32'(INH));
    check({tag, "_busy_inhibit"}, 32'(bok), 32'd1);
    device_xfer(ack, cap);
    repeat (30) @(negedge clock);
    check({tag, "_frame"}, 32'(cap), 32'(frame_of(b)));
    check({tag, "_done_once"}, 32'(done_cnt), 32'(d0 + 1));
    check({tag, "_ack"}, 32'(last_ack), 32'(ack));
    check({tag, "_no_err"}, 32'(err_cnt), 32'(e0));
    check({tag, "_released"}, 32'({clk_dl, data_dl}), 32'd0);
    check({tag, "_ready"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    int n, k, d0, e0;
    bit seen, bok;
    logic [9:0] cap1, cap2;
    logic [7:0] a_byte, b_byte;

    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'd0;
    repeat (3) @(negedge clock);
    check("reset_state", 32'({tx_ready, busy, clk_dl, data_dl, done, ack_ok, error}), 32'b1000000);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Inhibit timing, ACKed 0xED, un-ACKed 0xF4
    do_xfer("ed_ack", 8'hED, 1'b1);
    do_xfer("f4_nack", 8'hF4, 1'b0);

    // Random bytes with random ACK
    for (int i = 0; i < 4; i++) begin
      do_xfer("rand", 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Device never clocks: timeout
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clock);
    tx_valid = 1'b1; tx_data = 8'hAA;
    wait_rts(n, seen, bok);
    tx_valid = 1'b0;
    check("tmo_rts", 32'(seen), 32'd1);
    k = 0;
    for (int i = 0; i < TMO + 100; i++) begin
      @(negedge clock);
      k++;
      if (error) break;
    end
    check("tmo_latency", 32'(k), 32'(TMO));
    check("tmo_released", 32'({clk_dl, data_dl}), 32'd0);
    @(negedge clock);
    check("tmo_ready", 32'(tx_ready), 32'd1);
    check("tmo_pulse_width", 32'(error), 32'd0);
    check("tmo_no_done", 32'(done_cnt), 32'(d0));
    check("tmo_err_once", 32'(err_cnt), 32'(e0 + 1));

    // Reset during the 5th data bit
    d0 = done_cnt; e0 = err_cnt;
    @(negedge clock);
    tx_valid = 1'b1; tx_data = 8'h5C;
    wait_rts(n, seen, bok);
    tx_valid = 1'b0;
    check("rst_rts", 32'(seen), 32'd1);
    repeat (5) @(negedge clock);
    for (int e = 1; e <= 5; e++) begin
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clock);
      if (e < 5) begin
        dev_clk_low = 1'b0;
        repeat (10) @(negedge clock);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_lines", 32'({clk_dl, data_dl, busy}), 32'd0);
    dev_clk_low = 1'b0;
    repeat (40) @(negedge clock);
    check("rst_no_pulse", 32'({done_cnt, err_cnt}), 32'({d0, e0}));
    do_xfer("after_rst_ff", 8'hFF, 1'b1);

    // tx_valid held with tx_data changing; second byte waits for done
    a_byte = 8'($urandom); b_byte = ~a_byte;
    d0 = done_cnt;
    @(negedge clock);
    tx_valid = 1'b1; tx_data = a_byte;
    wait_rts(n, seen, bok);
    check("b2b_rts1", 32'(seen), 32'd1);
    fork
      device_xfer(1'b1, cap1);
      begin
        bit got_done, early;
        got_done = 1'b0; early = 1'b0;
        for (int i = 0; i < 2000; i++) begin
          @(negedge clock);
          if (done) begin
            got_done = 1'b1;
            tx_data = b_byte;
            break;
          end
          if (tx_ready) early = 1'b1;
          tx_data = 8'($urandom);
        end
        check("b2b_done", 32'(got_done), 32'd1);
        check("b2b_no_early_ready", 32'(early), 32'd0);
        @(negedge clock);
        check("b2b_idle_gap", 32'(tx_ready), 32'd1);
        @(negedge clock);
        check("b2b_accept", 32'(busy), 32'd1);
        tx_valid = 1'b0;
      end
    join
    check("b2b_frame1", 32'(cap1), 32'(frame_of(a_byte)));
    wait_rts(n, seen, bok);
    check("b2b_rts2", 32'(seen), 32'd1);
    device_xfer(1'b1, cap2);
    repeat (30) @(negedge clock);
    check("b2b_frame2", 32'(cap2), 32'(frame_of(b_byte)));
    check("b2b_done_cnt", 32'(done_cnt), 32'(d0 + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
